hazard_unit_md: RTL
===================

Name: hazard_unit_md

Overview:
- Parametrised successor to the five-stage pipeline's hazard/forwarding controller; sits beside the D/E/M/W pipeline registers.
- Generalises operand-slot count and T_new/T_use width.
- Adds a sequential multi-cycle multiply/divide busy tracker that stalls HI/LO consumers.
- Adds a saturating stall-cycle performance counter.

Parameters:
- SRC_NUM, 2, register source slots per instruction (slot 0 = rs/base, slot 1 = rt, ...).
- TW, 2, width of T_use/T_new fields; all-ones encodes T_NEW_IGNORE (no result).
- MULT_LAT, 5, busy cycles after a mult/multu start.
- DIV_LAT, 10, busy cycles after a div/divu start.
- CNT_W, 32, stall-counter width.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- D_src  in  SRC_NUM*5  D-stage source register numbers, slot i at [5i+4:5i]
- D_T_use  in  SRC_NUM*TW  D-stage T_use per slot
- E_src  in  SRC_NUM*5  E-stage source register numbers
- M_src  in  SRC_NUM*5  M-stage source register numbers
- E_wr_num / M_wr_num / W_wr_num  in  5 each  destination register per stage
- E_wr_en / M_wr_en / W_wr_en  in  1 each  register write enable per stage
- E_T_new / M_T_new / W_T_new  in  TW each  stage T_new
- D_md_use  in  1  D instruction reads/writes HI/LO or starts mult/div
- E_md_start  in  1  E instruction starts mult/div this cycle
- E_md_is_div  in  1  qualifies E_md_start: 1 = divide latency
- stall  out  1  freeze PC/FD, clear DE
- md_busy  out  1  mult/div unit busy
- fwd_D  out  SRC_NUM*2  forward select into D per slot
- fwd_E  out  SRC_NUM*2  forward select into E per slot
- fwd_M  out  SRC_NUM*2  forward select into M per slot
- stall_cnt  out  CNT_W  total stalled cycles, saturating

Behaviour:
- Match(X→Y, i): X_wr_en && X_wr_num == Y_src[i] && X_wr_num != 0.
- reg_stall:
  - OR over slots i of (Match(E→D,i) && E_T_new > D_T_use[i] && E_T_new != IGNORE).
  - Same term for M→D.
  - W never stalls.
- Forward selects (2 bits): 0 = DISABLE, 1 = FROM_E (DE PC+8), 2 = FROM_M (EM result), 3 = FROM_W (MW data).
  - fwd_D[i]: E if Match(E→D,i) && E_T_new == 0; else M if Match(M→D,i) && M_T_new == 0; else 0.
  - fwd_E[i]: M if Match(M→E,i) && M_T_new == 0; else W if Match(W→E,i) && W_T_new == 0; else 0.
  - fwd_M[i]: W if Match(W→M,i) && W_T_new == 0; else 0.
  - Nearest stage always wins.
  - All forward selects are combinational, zero latency.
- MD tracker FSM, states IDLE and BUSY, with a down-counter of width clog2(DIV_LAT+1):
  - IDLE + E_md_start: cnt ← E_md_is_div ? DIV_LAT : MULT_LAT; go to BUSY.
  - BUSY: cnt ← cnt−1 each cycle; when cnt == 1, go to IDLE next edge.
  - BUSY + E_md_start (only possible from a misbehaving D stage): restart the counter with the new latency; stay BUSY.
  - md_busy = (state == BUSY). It rises the cycle after the start edge and stays high exactly LAT cycles.
  - A latency parameter of 0 is illegal.
- md_stall = D_md_use && (E_md_start || md_busy).
- stall = reg_stall || md_stall (combinational).
- stall_cnt increments on every clk edge where stall == 1 and holds at all-ones.
- Asynchronous reset (reset == 0):
  - state = IDLE, cnt = 0, stall_cnt = 0, md_busy = 0.
  - stall and forward outputs follow their inputs combinationally.
  - Reset mid-BUSY aborts the operation immediately.
- Inputs with wr_num == 0 never match, so they never forward or stall.

Decomposition:
- Shared package/macros holds:
  - T_NEW_IGNORE
  - FWD_DISABLE / FWD_FROM_E / FWD_FROM_M / FWD_FROM_W
  - MD FSM state encodings
- One natural sub-module: md_busy_tracker. It holds the FSM, counter, md_busy output and start/latency inputs.
- The forwarding/stall comparators stay in the top level as a generate loop over SRC_NUM.

Test Plan:
- E: lw $8 (E_T_new=2); D: add reading $8 in slot 0 (T_use=1) → stall=1, fwd_D[0]=0; stall_cnt 0→1 after one edge.
- M: addu $9 (M_T_new=0); W: addu $9 (W_T_new=0); E slot 1 reads $9 → fwd_E[1]=2 (M wins over W).
- E_md_start=1, E_md_is_div=0, no D_md_use → md_busy high exactly 5 cycles starting next cycle; stall=0 throughout.
- div start, then D_md_use held high → stall=1 from the start cycle through all 10 busy cycles (11 cycles total); stall_cnt=11.
- E writes $0 with T_new=2 while D reads $0 → stall=0, all fwd=0.
- Assert reset low on the 3rd cycle of a divide → md_busy=0 and stall_cnt=0 immediately, without waiting for clk; after release, D_md_use does not stall.

Source files
------------

// File: rtl/hazard_unit_md_pkg.sv
// ----------------------------------------------------------------------------
// hazard_unit_md_pkg
// Shared constants for the hazard/forwarding controller and its mult/div
// busy tracker.
//   - T_NEW_IGNORE : "no result" T_new encoding at the default 2-bit width
//                    (the top level widens it to all-ones of TW bits)
//   - FWD_*        : forward-select encodings driven on fwd_D/fwd_E/fwd_M
//   - MD_*         : mult/div tracker FSM state encodings
//   - md_cnt_width : counter width able to hold the larger latency
// ----------------------------------------------------------------------------
package hazard_unit_md_pkg;

  localparam int unsigned TW_DEFAULT = 2;

  // All-ones means the instruction produces no register result.
  localparam logic [TW_DEFAULT-1:0] T_NEW_IGNORE = '1;

  // Forward-select encodings (2 bits per operand slot).
  localparam logic [1:0] FWD_DISABLE = 2'd0;  // use register-file / pipe value
  localparam logic [1:0] FWD_FROM_E  = 2'd1;  // DE stage PC+8 (link value)
  localparam logic [1:0] FWD_FROM_M  = 2'd2;  // EM stage ALU result
  localparam logic [1:0] FWD_FROM_W  = 2'd3;  // MW stage write-back data

  // Mult/div tracker states; kept as plain 1-bit constants so older
  // netlists that probe the state register still line up.
  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  // Down-counter width: large enough for whichever latency is longer, so a
  // configuration with MULT_LAT > DIV_LAT still loads correctly.
  function automatic int md_cnt_width(input int mult_lat, input int div_lat);
    int max_lat;
    max_lat = (mult_lat > div_lat) ? mult_lat : div_lat;
    return (max_lat < 1) ? 1 : $clog2(max_lat + 1);
  endfunction

endpackage : hazard_unit_md_pkg

// File: rtl/hazard_unit_md_md_busy_tracker.sv
// ----------------------------------------------------------------------------
// md_busy_tracker
// Tracks the multi-cycle multiply/divide unit. A start pulse loads a
// down-counter with the selected latency; md_busy is high for exactly that
// many cycles, beginning the cycle after the start edge.
// Ports:
//   clk        in  pipeline clock
//   reset      in  asynchronous, active-low reset (aborts any operation)
//   md_start   in  E-stage instruction starts mult/div this cycle
//   md_is_div  in  1 = divide latency, 0 = multiply latency
//   md_busy    out mult/div unit busy
// Both latency parameters must be at least 1.
// ----------------------------------------------------------------------------
module md_busy_tracker
  import hazard_unit_md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  localparam int CW = md_cnt_width(MULT_LAT, DIV_LAT);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  logic [0:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (md_start) begin
      // A start while already busy only happens if D failed to stall; the
      // newest operation owns HI/LO, so its latency replaces the old one.
      state_next = MD_BUSY;
      cnt_next   = md_is_div ? DIV_CNT : MULT_CNT;
    end else if (state_reg == MD_BUSY) begin
      cnt_next = cnt_reg - 1'b1;
      if (cnt_reg == CNT_LAST) begin
        state_next = MD_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= MD_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign md_busy = (state_reg == MD_BUSY);

endmodule : md_busy_tracker

// File: rtl/hazard_unit_md.sv
// ----------------------------------------------------------------------------
// hazard_unit_md
// Hazard and forwarding controller for the five-stage pipeline, generalised
// over operand-slot count and T_new/T_use width, with a mult/div busy
// tracker and a saturating stall-cycle counter.
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   D_src/E_src/M_src            per-stage source registers, slot i at [5i+4:5i]
//   D_T_use                      D-stage T_use per slot, slot i at [TWi+TW-1:TWi]
//   {E,M,W}_wr_num/_wr_en/_T_new per-stage destination, enable, T_new
//   D_md_use                     D instruction touches HI/LO or starts mult/div
//   E_md_start, E_md_is_div      E instruction starts mult/div (and which)
//   stall                        freeze PC/FD, clear DE
//   md_busy                      mult/div unit busy
//   fwd_D/fwd_E/fwd_M            2-bit forward select per slot
//   stall_cnt                    total stalled cycles, saturating
// ----------------------------------------------------------------------------
module hazard_unit_md
  import hazard_unit_md_pkg::*;
#(
  parameter int SRC_NUM  = 2,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SRC_NUM*5-1:0]  D_src,
  input  logic [SRC_NUM*TW-1:0] D_T_use,
  input  logic [SRC_NUM*5-1:0]  E_src,
  input  logic [SRC_NUM*5-1:0]  M_src,
  input  logic [4:0]            E_wr_num,
  input  logic [4:0]            M_wr_num,
  input  logic [4:0]            W_wr_num,
  input  logic                  E_wr_en,
  input  logic                  M_wr_en,
  input  logic                  W_wr_en,
  input  logic [TW-1:0]         E_T_new,
  input  logic [TW-1:0]         M_T_new,
  input  logic [TW-1:0]         W_T_new,
  input  logic                  D_md_use,
  input  logic                  E_md_start,
  input  logic                  E_md_is_div,
  output logic                  stall,
  output logic                  md_busy,
  output logic [SRC_NUM*2-1:0]  fwd_D,
  output logic [SRC_NUM*2-1:0]  fwd_E,
  output logic [SRC_NUM*2-1:0]  fwd_M,
  output logic [CNT_W-1:0]      stall_cnt
);

  // T_NEW_IGNORE widened to the configured T_new width.
  localparam logic [TW-1:0] T_IGNORE = '1;
  localparam logic [TW-1:0] T_ZERO   = '0;

  // Register 0 is hard-wired, so a write to it is never a real producer.
  logic e_wr_live, m_wr_live, w_wr_live;
  assign e_wr_live = E_wr_en && (E_wr_num != 5'd0);
  assign m_wr_live = M_wr_en && (M_wr_num != 5'd0);
  assign w_wr_live = W_wr_en && (W_wr_num != 5'd0);

  // A producer can only forward once its result exists (T_new == 0).
  logic e_ready, m_ready, w_ready;
  assign e_ready = (E_T_new == T_ZERO);
  assign m_ready = (M_T_new == T_ZERO);
  assign w_ready = (W_T_new == T_ZERO);

  logic [SRC_NUM-1:0] e_d_stall;
  logic [SRC_NUM-1:0] m_d_stall;

  genvar gi;
  generate
    for (gi = 0; gi < SRC_NUM; gi++) begin : g_slot
      logic [4:0]    d_src_i, e_src_i, m_src_i;
      logic [TW-1:0] d_t_use_i;
      logic          e_d_match, m_d_match, m_e_match, w_e_match, w_m_match;

      assign d_src_i   = D_src[5*gi +: 5];
      assign e_src_i   = E_src[5*gi +: 5];
      assign m_src_i   = M_src[5*gi +: 5];
      assign d_t_use_i = D_T_use[TW*gi +: TW];

      assign e_d_match = e_wr_live && (E_wr_num == d_src_i);
      assign m_d_match = m_wr_live && (M_wr_num == d_src_i);
      assign m_e_match = m_wr_live && (M_wr_num == e_src_i);
      assign w_e_match = w_wr_live && (W_wr_num == e_src_i);
      assign w_m_match = w_wr_live && (W_wr_num == m_src_i);

      // Stall when the result arrives later than this operand needs it.
      // W-stage results are always ready, so W never contributes.
      assign e_d_stall[gi] = e_d_match && (E_T_new > d_t_use_i) && (E_T_new != T_IGNORE);
      assign m_d_stall[gi] = m_d_match && (M_T_new > d_t_use_i) && (M_T_new != T_IGNORE);

      // Priority order gives the youngest producer precedence.
      assign fwd_D[2*gi +: 2] = (e_d_match && e_ready) ? FWD_FROM_E :
                                (m_d_match && m_ready) ? FWD_FROM_M :
                                                         FWD_DISABLE;
      assign fwd_E[2*gi +: 2] = (m_e_match && m_ready) ? FWD_FROM_M :
                                (w_e_match && w_ready) ? FWD_FROM_W :
                                                         FWD_DISABLE;
      assign fwd_M[2*gi +: 2] = (w_m_match && w_ready) ? FWD_FROM_W :
                                                         FWD_DISABLE;
    end
  endgenerate

  logic reg_stall;
  logic md_stall;

  assign reg_stall = (|e_d_stall) || (|m_d_stall);

  md_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_tracker (
    .clk       (clk),
    .reset     (reset),
    .md_start  (E_md_start),
    .md_is_div (E_md_is_div),
    .md_busy   (md_busy)
  );

  // The start cycle itself must also block a HI/LO consumer in D, since
  // md_busy only rises on the following cycle.
  assign md_stall = D_md_use && (E_md_start || md_busy);
  assign stall    = reg_stall || md_stall;

  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= '0;
    end else if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule : hazard_unit_md
